// File: rtl/evolved_circuit_tester.sv
// Clocked harness that sweeps every input vector of an asynchronous candidate circuit,
// scores it against a captured truth table and counts mismatched / oscillating vectors.
// Optional macro TESTER_GRAY_ORDER_EN applies the vectors in Gray order instead of binary order.
module evolved_circuit_tester #(
   parameter int IN_WIDTH      = 2,
   parameter int SETTLE_CYCLES = 4,
   parameter int SAMPLES       = 4,
   parameter int PASSES        = 2,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic                   i_start,
   input  logic [2**IN_WIDTH-1:0] i_expected,
   output logic [IN_WIDTH-1:0]    o_dut_in,
   input  logic                   i_dut_out,
   output logic                   o_busy,
   output logic                   o_done,
   output logic [CNT_WIDTH-1:0]   o_err_count,
   output logic [CNT_WIDTH-1:0]   o_unstable_count
);

   // state    | meaning
   // S_IDLE   | waiting for the first start after reset
   // S_SETTLE | vector applied, waiting for the circuit and synchroniser to settle
   // S_SAMPLE | sampling the synchronised output, watching for oscillation
   // S_NEXT   | scoring the vector, advancing index/pass
   // S_DONE   | results held until the next accepted start

   localparam int NVEC = 2**IN_WIDTH;
   localparam int TMAX = (SETTLE_CYCLES > SAMPLES) ? SETTLE_CYCLES : SAMPLES;
   localparam int TW   = $clog2(TMAX + 1);
   localparam int PW   = $clog2(PASSES + 1);

   localparam logic [TW-1:0]        TIMER_SETTLE = TW'(SETTLE_CYCLES - 1);
   localparam logic [TW-1:0]        TIMER_SAMPLE = TW'(SAMPLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX      = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_SAMPLE,
      S_NEXT,
      S_DONE
   } state_t;

   state_t r_state;
   state_t w_next_state;

   logic                 r_sync1;
   logic                 r_sync2;
   logic [NVEC-1:0]      r_expected;
   logic [IN_WIDTH-1:0]  r_index;
   logic [PW-1:0]        r_pass;
   logic [TW-1:0]        r_timer;
   logic                 r_first;
   logic                 r_unstable;
   logic [IN_WIDTH-1:0]  r_dut_in;
   logic [CNT_WIDTH-1:0] r_err;
   logic [CNT_WIDTH-1:0] r_uns;

   logic                 w_accept;
   logic                 w_timer_zero;
   logic                 w_last_index;
   logic [PW-1:0]        w_pass_next;
   logic                 w_run_end;
   logic                 w_mismatch;
   logic [IN_WIDTH-1:0]  w_index_next;

   function automatic logic [IN_WIDTH-1:0] f_apply(input logic [IN_WIDTH-1:0] idx);
`ifdef TESTER_GRAY_ORDER_EN
      return idx ^ (idx >> 1);
`else
      return idx;
`endif
   endfunction

   assign w_accept     = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_timer_zero = (r_timer == '0);
   assign w_last_index = &r_index;
   assign w_index_next = r_index + 1'b1;
   assign w_pass_next  = w_last_index ? (r_pass + 1'b1) : r_pass;
   assign w_run_end    = (w_pass_next == PW'(PASSES));
   // r_dut_in already holds the applied (possibly Gray-coded) vector
   assign w_mismatch   = (r_first != r_expected[r_dut_in]);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE, S_DONE: if (w_accept) w_next_state = S_SETTLE;
         S_SETTLE:       if (w_timer_zero) w_next_state = S_SAMPLE;
         S_SAMPLE:       if (w_timer_zero) w_next_state = S_NEXT;
         S_NEXT:         w_next_state = w_run_end ? S_DONE : S_SETTLE;
         default:        w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= i_dut_out;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_expected <= '0;
         r_index    <= '0;
         r_pass     <= '0;
         r_timer    <= '0;
         r_first    <= 1'b0;
         r_unstable <= 1'b0;
         r_dut_in   <= '0;
         r_err      <= '0;
         r_uns      <= '0;
      end else if (w_accept) begin
         r_expected <= i_expected;
         r_index    <= '0;
         r_pass     <= '0;
         r_timer    <= TIMER_SETTLE;
         r_dut_in   <= f_apply('0);
         r_err      <= '0;
         r_uns      <= '0;
      end else begin
         case (r_state)
            S_SETTLE: r_timer <= w_timer_zero ? TIMER_SAMPLE : (r_timer - 1'b1);
            S_SAMPLE: begin
               if (r_timer == TIMER_SAMPLE) begin
                  r_first    <= r_sync2;
                  r_unstable <= 1'b0;
               end else if (r_sync2 != r_first) begin
                  r_unstable <= 1'b1;
               end
               if (!w_timer_zero) r_timer <= r_timer - 1'b1;
            end
            S_NEXT: begin
               if (r_unstable) begin
                  if (r_uns != CNT_MAX) r_uns <= r_uns + 1'b1;
                  if (r_err != CNT_MAX) r_err <= r_err + 1'b1;
               end else if (w_mismatch) begin
                  if (r_err != CNT_MAX) r_err <= r_err + 1'b1;
               end
               r_index <= w_index_next;
               r_pass  <= w_pass_next;
               if (!w_run_end) begin
                  r_dut_in <= f_apply(w_index_next);
                  r_timer  <= TIMER_SETTLE;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_dut_in         = r_dut_in;
   assign o_busy           = (r_state == S_SETTLE) || (r_state == S_SAMPLE) || (r_state == S_NEXT);
   assign o_done           = (r_state == S_DONE);
   assign o_err_count      = r_err;
   assign o_unstable_count = r_uns;

endmodule
